// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the boot-time program loader.
//   loader_state_t : frame-parser FSM states
//   LOADER_MAGIC   : frame start byte
//   LOADER_LEN_W   : width of the word-count field in the frame header
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CHECK
  } loader_state_t;

  localparam logic [7:0] LOADER_MAGIC = 8'hB5;
  localparam int         LOADER_LEN_W = 16;

endpackage

// File: rtl/loader_timeout.sv
// loader_timeout: inter-byte gap watchdog for a frame in progress.
//   clk, reset : clock, async active-high reset
//   enable     : a frame is in progress; the counter is held at 0 otherwise
//   kick       : a byte arrived this cycle; restarts the gap count
//   expired    : one-cycle pulse on the TIMEOUT_CYCLES-th consecutive idle cycle
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                cnt_q <= '0;
    else if (!enable || kick) cnt_q <= '0;
    else if (cnt_q != LAST)   cnt_q <= cnt_q + CW'(1);
  end

  // A byte in the expiry cycle wins, hence the !kick term.
  assign expired = enable && !kick && (cnt_q == LAST);

endmodule

// File: rtl/program_loader.sv
// program_loader: receives a framed byte stream (MAGIC, LEN_HI, LEN_LO,
// LEN big-endian words, CHK), writes the words to program memory from
// address 0 and releases the CPU only after a frame verifies.
//   clk, reset          : clock, async active-high reset
//   rx_valid, rx_data   : one-cycle byte strobe and byte from the receiver
//   mem_we/addr/din     : program memory write port, one pulse per word
//   cpu_reset           : 1 holds the CPU
//   busy                : frame in progress
//   load_done/load_error: sticky status of the most recent frame
module program_loader
  import loader_pkg::*;
#(
  parameter int CODE_WIDTH     = 13,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  mem_we,
  output logic [CODE_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_din,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_error
);

  localparam logic [31:0] CAPACITY = 32'd1 << CODE_WIDTH;

  loader_state_t           state_q;
  logic [7:0]              len_hi_q;
  logic [LOADER_LEN_W-1:0] remain_q;
  logic [CODE_WIDTH-1:0]   wptr_q;
  logic [7:0]              hi_q;
  logic [7:0]              chk_q;
  logic                    mem_we_q;
  logic [CODE_WIDTH-1:0]   mem_addr_q;
  logic [15:0]             mem_din_q;
  logic                    cpu_reset_q;
  logic                    load_done_q;
  logic                    load_error_q;

  logic [LOADER_LEN_W-1:0] len_d;
  logic                    len_too_big;
  logic                    expired;

  assign len_d       = {len_hi_q, rx_data};
  assign len_too_big = 32'(len_d) > CAPACITY;

  loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .enable  (busy),
    .kick    (rx_valid),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      len_hi_q     <= '0;
      remain_q     <= '0;
      wptr_q       <= '0;
      hi_q         <= '0;
      chk_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (expired) begin
        // cpu_reset is untouched: it is already 1 in any non-idle state.
        load_error_q <= 1'b1;
        state_q      <= ST_IDLE;
      end else if (rx_valid) begin
        case (state_q)
          ST_IDLE: begin
            if (rx_data == LOADER_MAGIC) begin
              state_q      <= ST_LEN_HI;
              cpu_reset_q  <= 1'b1;
              load_done_q  <= 1'b0;
              load_error_q <= 1'b0;
              wptr_q       <= '0;
              chk_q        <= '0;
            end
          end
          ST_LEN_HI: begin
            len_hi_q <= rx_data;
            state_q  <= ST_LEN_LO;
          end
          ST_LEN_LO: begin
            remain_q <= len_d;
            if (len_d == '0) begin
              state_q <= ST_CHECK;
            end else if (len_too_big) begin
              load_error_q <= 1'b1;
              state_q      <= ST_IDLE;
            end else begin
              state_q <= ST_DATA_HI;
            end
          end
          ST_DATA_HI: begin
            hi_q    <= rx_data;
            chk_q   <= chk_q ^ rx_data;
            state_q <= ST_DATA_LO;
          end
          ST_DATA_LO: begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= wptr_q;
            mem_din_q  <= {hi_q, rx_data};
            // Wraps to 0 after a full-capacity frame; never used after that.
            wptr_q     <= wptr_q + CODE_WIDTH'(1);
            chk_q      <= chk_q ^ rx_data;
            remain_q   <= remain_q - LOADER_LEN_W'(1);
            state_q    <= (remain_q == LOADER_LEN_W'(1)) ? ST_CHECK : ST_DATA_HI;
          end
          ST_CHECK: begin
            if (rx_data == chk_q) begin
              load_done_q <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else begin
              load_error_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign cpu_reset  = cpu_reset_q;
  // Pure decode of the state register; no input feeds it.
  assign busy       = (state_q != ST_IDLE);
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed frames for program_loader. Stimulus pushes each
// expected memory write into a queue; a monitor pops and compares on mem_we.
module tb_program_loader;

  localparam int CW = 13;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          mem_we;
  logic [CW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic          cpu_reset;
  logic          busy;
  logic          load_done;
  logic          load_error;

  program_loader #(.CODE_WIDTH(CW), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  wr_t           exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [CW-1:0] ea;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic status(input string name, input logic done, input logic err,
                        input logic cpu, input logic bsy);
    chk({name, ".load_done"},  {31'd0, load_done},  {31'd0, done});
    chk({name, ".load_error"}, {31'd0, load_error}, {31'd0, err});
    chk({name, ".cpu_reset"},  {31'd0, cpu_reset},  {31'd0, cpu});
    chk({name, ".busy"},       {31'd0, busy},       {31'd0, bsy});
  endtask

  // All drives start and end on a negedge; consecutive sends are back-to-back.
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame(input logic [15:0] len);
    send(8'hB5);
    send(len[15:8]);
    send(len[7:0]);
    ea = '0;
  endtask

  task automatic send_word(input logic [15:0] w);
    exp_q.push_back('{addr: ea, data: w});
    ea++;
    send(w[15:8]);
    send(w[7:0]);
  endtask

  // Write monitor / scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (!reset && mem_we) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_din);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {19'd0, mem_addr}, {19'd0, e.addr});
        chk("wr_data", {16'd0, mem_din},  {16'd0, e.data});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    #2 reset = 1'b1;
    #1;
    chk("rst.mem_we",   {31'd0, mem_we}, 32'd0);
    chk("rst.mem_addr", {19'd0, mem_addr}, 32'd0);
    chk("rst.mem_din",  {16'd0, mem_din}, 32'd0);
    status("rst", 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    reset = 1'b0;
    idle(1);

    // Good frame: CHK = 12^34^AB^CD = 40.
    start_frame(16'd2);
    send_word(16'h1234);
    send_word(16'hABCD);
    send(8'h40);
    status("good", 1'b1, 1'b0, 1'b0, 1'b0);

    // Garbage in IDLE, then reload from address 0 (CHK = 55^AA = FF).
    send(8'h00);
    send(8'hFF);
    idle(2);
    status("garbage", 1'b1, 1'b0, 1'b0, 1'b0);
    send(8'hB5);
    status("reload_magic", 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'h00);
    send(8'h01);
    ea = '0;
    send_word(16'h55AA);
    send(8'hFF);
    status("reload", 1'b1, 1'b0, 1'b0, 1'b0);

    // Bad checksum: words still written.
    start_frame(16'd2);
    send_word(16'h1234);
    send_word(16'hABCD);
    send(8'h41);
    status("badchk", 1'b0, 1'b1, 1'b1, 1'b0);

    // Oversize: 0x2001 > 8192.
    send(8'hB5);
    status("over_magic", 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'h20);
    send(8'h01);
    status("oversize", 1'b0, 1'b1, 1'b1, 1'b0);

    // Empty frame, CHK of no bytes = 00.
    start_frame(16'd0);
    send(8'h00);
    status("empty", 1'b1, 1'b0, 1'b0, 1'b0);

    // Timeout: error lands on the 16th idle cycle, not the 15th.
    start_frame(16'd1);
    send(8'h12);
    idle(15);
    status("to_15", 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1);
    status("to_16", 1'b0, 1'b1, 1'b1, 1'b0);

    // Byte arriving in the expiry cycle wins (CHK = 12^34 = 26).
    start_frame(16'd1);
    exp_q.push_back('{addr: '0, data: 16'h1234});
    send(8'h12);
    idle(15);
    send(8'h34);
    status("to_save", 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'h26);
    status("to_done", 1'b1, 1'b0, 1'b0, 1'b0);

    // Full capacity: words 0..8191. Each hi byte 0..31 appears 256 times and
    // each lo byte 0..255 appears 32 times, so the XOR checksum is 00.
    start_frame(16'h2000);
    for (int i = 0; i < 8192; i++) send_word(i[15:0]);
    send(8'h00);
    status("full", 1'b1, 1'b0, 1'b0, 1'b0);

    // Async reset while waiting for a lo byte (mem_addr=1, mem_din=ABCD held).
    start_frame(16'd3);
    send_word(16'h1234);
    send_word(16'hABCD);
    send(8'hEF);
    #1 reset = 1'b1;
    #1;
    chk("arst.mem_we",   {31'd0, mem_we}, 32'd0);
    chk("arst.mem_addr", {19'd0, mem_addr}, 32'd0);
    chk("arst.mem_din",  {16'd0, mem_din}, 32'd0);
    status("arst", 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    idle(1);

    start_frame(16'd2);
    send_word(16'h1234);
    send_word(16'hABCD);
    send(8'h40);
    status("post_rst", 1'b1, 1'b0, 1'b0, 1'b0);

    idle(3);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader that sits directly upstream of the CPU's program memory. It receives a framed byte stream from the serial receiver, assembles big-endian 16-bit instruction words, and writes them into program memory from address 0. It holds the CPU in reset until a frame loads and checksums correctly. A later frame triggers a reload.

## Interface
- `CODE_WIDTH`, 13: program memory address width; capacity is 2^CODE_WIDTH words.
- `TIMEOUT_CYCLES`, 1_000_000: idle-byte gap that aborts a frame in progress.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  one-cycle strobe per received byte; may be asserted every cycle.
- `rx_data`  in  8  received byte, valid when `rx_valid`=1.
- `mem_we`  out  1  program memory write enable, one-cycle pulse per word.
- `mem_addr`  out  CODE_WIDTH  program memory write address.
- `mem_din`  out  16  program memory write data.
- `cpu_reset`  out  1  reset to the CPU; 1 = CPU held.
- `busy`  out  1  a frame is in progress.
- `load_done`  out  1  sticky: last frame loaded and verified.
- `load_error`  out  1  sticky: last frame failed.

## Operation
- Frame format: MAGIC (0xB5), LEN_HI, LEN_LO, then LEN words sent hi byte then lo byte, then CHK.
  - LEN is the 16-bit word count.
  - CHK is the XOR of all data bytes; the header is excluded.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK.
- IDLE:
  - A byte equal to MAGIC moves to LEN_HI. All other bytes are ignored.
  - Accepting MAGIC sets `cpu_reset`=1 and clears `load_done` and `load_error`.
- LEN_LO: the length is latched.
  - LEN=0 goes straight to CHECK.
  - LEN > 2^CODE_WIDTH sets `load_error` and returns to IDLE.
  - Otherwise go to DATA_HI.
- DATA_HI: latch the hi byte.
- DATA_LO, on the lo byte:
  - Write {hi,lo} at the current address.
  - Increment the address; the internal write pointer resets to 0 at MAGIC.
  - Decrement the remaining count.
  - If the count reaches 0, go to CHECK; otherwise go to DATA_HI.
- Checksum accumulator: cleared at MAGIC, XOR-updated with every data byte.
- CHECK: compare the received byte with the accumulator, then return to IDLE.
  - Match: `load_done`=1 and `cpu_reset`=0.
  - Mismatch: `load_error`=1 and `cpu_reset` stays 1.
- Timeout: in any state except IDLE, `TIMEOUT_CYCLES` consecutive cycles without `rx_valid` set `load_error`=1 and return to IDLE. `cpu_reset` stays 1.
- `busy` = (state != IDLE).
- A MAGIC byte received mid-frame is treated as data, never as a restart.

## Timing
- Reset values: state IDLE, `mem_we`=0, `mem_addr`=0, `mem_din`=0, `cpu_reset`=1, `busy`=0, `load_done`=0, `load_error`=0.
- All outputs are registered. Each effect of a byte is visible on the clock edge after that byte's `rx_valid` cycle:
  - `mem_we` pulse.
  - `cpu_reset` change.
  - `load_done` / `load_error` update.
- `mem_addr` and `mem_din` are valid while `mem_we`=1. `mem_addr` holds its value otherwise.
- Back-to-back bytes (`rx_valid` every cycle) are sustained with no stalls; there is no backpressure.
- Timeout counter:
  - Resets on every `rx_valid` and on entry to IDLE.
  - Expires when the counter equals TIMEOUT_CYCLES-1 without `rx_valid`.
  - If `rx_valid` arrives in the expiry cycle, the byte wins and there is no timeout.
- LEN = 2^CODE_WIDTH: the last write goes to address 2^CODE_WIDTH-1. The write pointer wraps to 0 but is unused afterwards.
- Reset mid-frame: all registers return to reset values. Words already written stay in memory. The CPU stays held until a full valid frame is received.

## Structure
- Shared package `loader_pkg` holds:
  - the `loader_state_t` enum,
  - the `LOADER_MAGIC` = 8'hB5 constant,
  - the length-field width (16).
- One sub-module is natural: `loader_timeout`.
  - Parameterised counter of width $clog2(TIMEOUT_CYCLES).
  - Inputs: `clk`, `reset`, `enable`, `kick`.
  - Output: `expired`, a one-cycle pulse.
- Everything else lives in `program_loader`.

## Test plan
- Good frame: B5 00 02 12 34 AB CD, CHK=12^34^AB^CD=0x40.
  - Writes 0x1234@0 and 0xABCD@1.
  - `load_done`=1 and `cpu_reset`=0 one cycle after CHK.
- Bad checksum: same frame with CHK=0x41.
  - Both words written.
  - `load_error`=1 and `cpu_reset` stays 1.
- Oversize and empty frames:
  - B5 20 01 gives `load_error`=1 after LEN_LO with no writes.
  - B5 00 00 00 gives `load_done`=1 with no writes.
- Timeout with TIMEOUT_CYCLES=16: B5 00 01 12, then silence.
  - `load_error`=1 at the 16th idle cycle.
  - A byte arriving exactly at cycle 16 prevents the error.
- Reload and garbage, after a good load:
  - Bytes 00 FF in IDLE are ignored.
  - A new B5 sets `cpu_reset`=1, clears `load_done`, and the next frame writes from address 0.
- Async reset asserted mid-DATA_LO:
  - Outputs match the reset values immediately, without waiting for a clock edge.
  - A subsequent good frame loads correctly.
